// File: rtl/anti_theft_pkg.sv
// Shared definitions for the anti-theft controller: FSM state encoding,
// parameter-select codes and the power-on delay values.
package anti_theft_pkg;

    typedef enum logic [2:0] {
        ST_ARMED       = 3'd0,
        ST_TRIGGERED   = 3'd1,
        ST_SOUND_ALARM = 3'd2,
        ST_DISARMED    = 3'd3,
        ST_WAIT_OPEN   = 3'd4,
        ST_WAIT_CLOSE  = 3'd5,
        ST_ARM_DELAY   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SEL_ARM       = 2'b00,
        SEL_DRIVER    = 2'b01,
        SEL_PASSENGER = 2'b10,
        SEL_ALARM     = 2'b11
    } time_sel_t;

    localparam logic [3:0] DEF_ARM_DELAY       = 4'd6;
    localparam logic [3:0] DEF_DRIVER_DELAY    = 4'd8;
    localparam logic [3:0] DEF_PASSENGER_DELAY = 4'd15;
    localparam logic [3:0] DEF_ALARM_ON        = 4'd10;

endpackage

// File: rtl/anti_theft_controller_time_param_regs.sv
// Four 4-bit programmable delay registers with one write port and one
// combinational select read port; index order follows time_sel_t.
module time_param_regs
    import anti_theft_pkg::*;
#(
    parameter logic [3:0] ARM_DELAY_DEF       = DEF_ARM_DELAY,
    parameter logic [3:0] DRIVER_DELAY_DEF    = DEF_DRIVER_DELAY,
    parameter logic [3:0] PASSENGER_DELAY_DEF = DEF_PASSENGER_DELAY,
    parameter logic [3:0] ALARM_ON_DEF        = DEF_ALARM_ON
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [1:0] wr_sel,
    input  logic [3:0] wr_data,
    input  logic [1:0] rd_sel,
    output logic [3:0] rd_data
);

    logic [15:0] param_flat;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_param
            localparam logic [3:0] RST_VAL = (gi == 0) ? ARM_DELAY_DEF :
                                             (gi == 1) ? DRIVER_DELAY_DEF :
                                             (gi == 2) ? PASSENGER_DELAY_DEF :
                                                         ALARM_ON_DEF;
            logic [3:0] param_reg;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    param_reg <= RST_VAL;
                end else if (wr_en && (wr_sel == 2'(gi))) begin
                    param_reg <= wr_data;
                end
            end

            assign param_flat[gi*4 +: 4] = param_reg;
        end
    endgenerate

    always_comb begin
        rd_data = param_flat[3:0];
        case (rd_sel)
            2'b00:   rd_data = param_flat[3:0];
            2'b01:   rd_data = param_flat[7:4];
            2'b10:   rd_data = param_flat[11:8];
            default: rd_data = param_flat[15:12];
        endcase
    end

endmodule

// File: rtl/anti_theft_controller.sv
// Anti-theft control FSM: drives the external timer, status LED and siren.
// Optional fuel-pump interlock is enabled with `define FUEL_PUMP_LOCK_EN.
module anti_theft_controller
    import anti_theft_pkg::*;
#(
    parameter logic [3:0] ARM_DELAY_DEF       = DEF_ARM_DELAY,
    parameter logic [3:0] DRIVER_DELAY_DEF    = DEF_DRIVER_DELAY,
    parameter logic [3:0] PASSENGER_DELAY_DEF = DEF_PASSENGER_DELAY,
    parameter logic [3:0] ALARM_ON_DEF        = DEF_ALARM_ON
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       reprogram,
    input  logic [1:0] time_sel,
    input  logic [3:0] time_value,
    input  logic       one_hz_enable,
    input  logic       expired,
`ifdef FUEL_PUMP_LOCK_EN
    input  logic       hidden_sw,
    input  logic       brake,
    output logic       fuel_pump,
`endif
    output logic       start_timer,
    output logic [3:0] value,
    output logic       status_led,
    output logic       siren,
    output logic [2:0] state_dbg
);

    state_t     state_reg, state_next;
    logic       start_reg, start_next;
    logic       start_d1_reg;
    logic [3:0] value_reg, value_next;
    logic       led_reg, led_next;
    logic       siren_reg, siren_next;
    logic       alarm_run_reg, alarm_run_next;
    logic [1:0] rd_sel;
    logic [3:0] param_q;
    logic       any_door;
    logic       exp_valid;

    time_param_regs #(
        .ARM_DELAY_DEF      (ARM_DELAY_DEF),
        .DRIVER_DELAY_DEF   (DRIVER_DELAY_DEF),
        .PASSENGER_DELAY_DEF(PASSENGER_DELAY_DEF),
        .ALARM_ON_DEF       (ALARM_ON_DEF)
    ) u_params (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (reprogram),
        .wr_sel (time_sel),
        .wr_data(time_value),
        .rd_sel (rd_sel),
        .rd_data(param_q)
    );

    assign any_door  = door_driver | door_pass;
    // The timer's expired flag is stale until it has seen the load pulse.
    assign exp_valid = expired & ~start_reg & ~start_d1_reg;

    always_comb begin
        rd_sel = SEL_ARM;
        case (state_reg)
            ST_ARMED:       rd_sel = door_driver ? SEL_DRIVER : SEL_PASSENGER;
            ST_SOUND_ALARM: rd_sel = SEL_ALARM;
            default:        rd_sel = SEL_ARM;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        start_next     = 1'b0;
        value_next     = value_reg;
        alarm_run_next = alarm_run_reg;
        if (reprogram) begin
            state_next = ST_ARMED;
        end else if (ignition && (state_reg != ST_DISARMED)) begin
            state_next = ST_DISARMED;
        end else begin
            case (state_reg)
                ST_ARMED: begin
                    if (any_door) begin
                        state_next = ST_TRIGGERED;
                        start_next = 1'b1;
                        value_next = param_q;
                    end
                end
                ST_TRIGGERED: begin
                    if (exp_valid) state_next = ST_SOUND_ALARM;
                end
                ST_SOUND_ALARM: begin
                    // alarm_run_reg: siren timer loaded with all doors closed
                    if (any_door) begin
                        alarm_run_next = 1'b0;
                    end else if (!alarm_run_reg) begin
                        start_next     = 1'b1;
                        value_next     = param_q;
                        alarm_run_next = 1'b1;
                    end else if (exp_valid) begin
                        state_next = ST_ARMED;
                    end
                end
                ST_DISARMED: begin
                    if (!ignition) state_next = ST_WAIT_OPEN;
                end
                ST_WAIT_OPEN: begin
                    if (door_driver) state_next = ST_WAIT_CLOSE;
                end
                ST_WAIT_CLOSE: begin
                    if (!door_driver) begin
                        state_next = ST_ARM_DELAY;
                        start_next = 1'b1;
                        value_next = param_q;
                    end
                end
                ST_ARM_DELAY: begin
                    if (any_door)       state_next = ST_WAIT_CLOSE;
                    else if (exp_valid) state_next = ST_ARMED;
                end
                default: state_next = ST_ARMED;
            endcase
        end
        if (state_next != ST_SOUND_ALARM) alarm_run_next = 1'b0;
    end

    always_comb begin
        siren_next = (state_next == ST_SOUND_ALARM);
        led_next   = 1'b0;
        case (state_next)
            ST_TRIGGERED, ST_SOUND_ALARM: led_next = 1'b1;
            ST_ARMED: begin
                if ((state_reg != ST_ARMED) || reprogram) led_next = 1'b0;
                else                                      led_next = led_reg ^ one_hz_enable;
            end
            default: led_next = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_ARMED;
            start_reg     <= 1'b0;
            start_d1_reg  <= 1'b0;
            value_reg     <= 4'd0;
            led_reg       <= 1'b0;
            siren_reg     <= 1'b0;
            alarm_run_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            start_reg     <= start_next;
            start_d1_reg  <= start_reg;
            value_reg     <= value_next;
            led_reg       <= led_next;
            siren_reg     <= siren_next;
            alarm_run_reg <= alarm_run_next;
        end
    end

    assign start_timer = start_reg;
    assign value       = value_reg;
    assign status_led  = led_reg;
    assign siren       = siren_reg;
    assign state_dbg   = state_reg;

`ifdef FUEL_PUMP_LOCK_EN
    logic fuel_pump_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fuel_pump_reg <= 1'b0;
        end else if (ignition && hidden_sw && brake) begin
            fuel_pump_reg <= 1'b1;
        end else if (!ignition) begin
            fuel_pump_reg <= 1'b0;
        end
    end

    assign fuel_pump = fuel_pump_reg;
`endif

endmodule

// File: tb/tb_anti_theft_controller.sv
// Directed bench for anti_theft_controller with a behavioural timer whose
// one-second tick is 10 clock cycles.
module tb_anti_theft_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ignition = 1'b0;
    logic       door_driver = 1'b0;
    logic       door_pass = 1'b0;
    logic       reprogram = 1'b0;
    logic [1:0] time_sel = 2'b00;
    logic [3:0] time_value = 4'd0;
    logic       one_hz_enable;
    logic       expired;
    logic       start_timer;
    logic [3:0] value;
    logic       status_led;
    logic       siren;
    logic [2:0] state_dbg;
`ifdef FUEL_PUMP_LOCK_EN
    logic       hidden_sw = 1'b0;
    logic       brake = 1'b0;
    logic       fuel_pump;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    anti_theft_controller dut (
        .clock        (clock),
        .reset        (reset),
        .ignition     (ignition),
        .door_driver  (door_driver),
        .door_pass    (door_pass),
        .reprogram    (reprogram),
        .time_sel     (time_sel),
        .time_value   (time_value),
        .one_hz_enable(one_hz_enable),
        .expired      (expired),
`ifdef FUEL_PUMP_LOCK_EN
        .hidden_sw    (hidden_sw),
        .brake        (brake),
        .fuel_pump    (fuel_pump),
`endif
        .start_timer  (start_timer),
        .value        (value),
        .status_led   (status_led),
        .siren        (siren),
        .state_dbg    (state_dbg)
    );

    // Timer model: 1 Hz tick every 10 cycles, loaded by start_timer.
    logic       tmr_rst_n = 1'b0;
    logic [3:0] tick_cnt;
    logic [3:0] tmr_count;
    logic       tmr_expired;

    assign one_hz_enable = (tick_cnt == 4'd9);
    assign expired       = tmr_expired;

    always @(posedge clock) begin
        if (!tmr_rst_n) begin
            tick_cnt    <= 4'd0;
            tmr_count   <= 4'd0;
            tmr_expired <= 1'b0;
        end else begin
            tick_cnt <= (tick_cnt == 4'd9) ? 4'd0 : tick_cnt + 4'd1;
            if (start_timer) begin
                tmr_count   <= value;
                tmr_expired <= 1'b0;
            end else if (one_hz_enable && !tmr_expired) begin
                if (tmr_count <= 4'd1) tmr_expired <= 1'b1;
                tmr_count <= (tmr_count == 4'd0) ? 4'd0 : tmr_count - 4'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, act);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int n = 0;
        while (state_dbg !== s && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(state_dbg), 32'(s));
    endtask

    initial begin
        int n;
        int saw_start;

        // Reset state
        repeat (3) step();
        check("rst_state", 32'(state_dbg), 0);
        check("rst_start", 32'(start_timer), 0);
        check("rst_value", 32'(value), 0);
        check("rst_led", 32'(status_led), 0);
        check("rst_siren", 32'(siren), 0);
        reset = 1'b1;
        tmr_rst_n = 1'b1;
        repeat (2) step();

        // Driver door trigger, then alarm with passenger door held open
        door_driver = 1'b1;
        step();
        check("trig_state", 32'(state_dbg), 1);
        check("trig_start", 32'(start_timer), 1);
        check("trig_value", 32'(value), 8);
        check("trig_led", 32'(status_led), 1);
        door_driver = 1'b0;
        step();
        check("trig_start_drop", 32'(start_timer), 0);
        wait_state("alarm_state", 3'd2, 150);
        check("alarm_siren", 32'(siren), 1);
        door_pass = 1'b1;
        saw_start = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (start_timer) saw_start++;
        end
        check("alarm_no_start", 32'(saw_start), 0);
        check("alarm_hold_state", 32'(state_dbg), 2);
        door_pass = 1'b0;
        n = 0;
        while (!start_timer && n < 5) begin
            step();
            n++;
        end
        check("alarm_start", 32'(start_timer), 1);
        check("alarm_value", 32'(value), 10);
        wait_state("alarm_to_armed", 3'd0, 200);
        check("armed_siren_off", 32'(siren), 0);

        // Both doors: driver priority, then ignition disarms
        door_driver = 1'b1;
        door_pass = 1'b1;
        step();
        check("both_state", 32'(state_dbg), 1);
        check("both_value", 32'(value), 8);
        door_driver = 1'b0;
        door_pass = 1'b0;
        step();
        ignition = 1'b1;
        step();
        check("ign_state", 32'(state_dbg), 3);
        check("ign_led", 32'(status_led), 0);
        check("ign_siren", 32'(siren), 0);

        // Arm sequence with a reopen during the delay
        ignition = 1'b0;
        step();
        check("wait_open", 32'(state_dbg), 4);
        door_driver = 1'b1;
        step();
        check("wait_close", 32'(state_dbg), 5);
        door_driver = 1'b0;
        step();
        check("arm_delay_state", 32'(state_dbg), 6);
        check("arm_delay_start", 32'(start_timer), 1);
        check("arm_delay_value", 32'(value), 6);
        repeat (20) step();
        door_pass = 1'b1;
        step();
        check("reopen_state", 32'(state_dbg), 5);
        door_pass = 1'b0;
        step();
        check("reclose_state", 32'(state_dbg), 6);
        wait_state("armed_again", 3'd0, 150);
        check("armed_led_entry", 32'(status_led), 0);
        n = 0;
        while (status_led == 1'b0 && n < 30) begin
            step();
            n++;
        end
        check("led_rise", 32'(status_led), 1);
        n = 0;
        while (status_led == 1'b1 && n < 30) begin
            step();
            n++;
        end
        check("led_half_period", 32'(n), 10);

        // Reprogram driver delay, trigger, then reset mid-TRIGGERED
        time_sel = 2'b01;
        time_value = 4'd3;
        reprogram = 1'b1;
        step();
        check("reprog_state", 32'(state_dbg), 0);
        reprogram = 1'b0;
        step();
        door_driver = 1'b1;
        step();
        check("reprog_trig_state", 32'(state_dbg), 1);
        check("reprog_value", 32'(value), 3);
        door_driver = 1'b0;
        step();
        reset = 1'b0;
        #2;
        check("mid_rst_state", 32'(state_dbg), 0);
        check("mid_rst_start", 32'(start_timer), 0);
        check("mid_rst_value", 32'(value), 0);
        check("mid_rst_led", 32'(status_led), 0);
        check("mid_rst_siren", 32'(siren), 0);
        repeat (2) step();
        reset = 1'b1;
        step();
        door_driver = 1'b1;
        step();
        check("post_rst_value", 32'(value), 8);
        door_driver = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
